// File: rtl/reg_file_sb.sv
// Register file with one decoded write port, two combinational read ports with
// write-through bypass, and a per-register pending-write scoreboard.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic [DATA_W-1:0]        rd_data1,
  output logic [DATA_W-1:0]        rd_data2,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_dst,
  output logic                     rd_busy1,
  output logic                     rd_busy2,
  output logic [(1<<ADDR_W)-1:0]   pend_mask
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;

  logic [NREGS-1:0]  wr_wl;
  logic [NREGS-1:0]  iss_wl;
  logic [NREGS-1:0]  zero_keep;

  logic              hit1;
  logic              hit2;
  logic              zero1;
  logic              zero2;

  // Register 0 is excluded from every wordline when it is hardwired to zero.
  always_comb begin
    zero_keep = '1;
    if (ZERO_REG != 0) begin
      zero_keep[0] = 1'b0;
    end
  end

  // One-hot write and issue wordlines.
  always_comb begin
    wr_wl  = (NREGS'(wr_en) << wr_addr) & zero_keep;
    iss_wl = (NREGS'(iss_valid) << iss_dst) & zero_keep;
  end

  // Storage next state: each register loads on its own wordline.
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) begin
      regs_d[i] = regs_q[i];
      if (wr_wl[i]) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Scoreboard: a new issue supersedes a same-cycle writeback of the old producer.
  always_comb begin
    pend_d = ((pend_q & ~wr_wl) | iss_wl) & zero_keep;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_mask = pend_q;

  // Per-port bypass hit and zero-register detection.
  always_comb begin
    zero1 = (ZERO_REG != 0) && (rd_addr1 == '0);
    zero2 = (ZERO_REG != 0) && (rd_addr2 == '0);
    hit1  = wr_en && (wr_addr == rd_addr1) && !zero1;
    hit2  = wr_en && (wr_addr == rd_addr2) && !zero2;
  end

  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    if (zero1) begin
      rd_data1 = '0;
    end else if (hit1) begin
      rd_data1 = wr_data;
    end
  end

  always_comb begin
    rd_data2 = regs_q[rd_addr2];
    if (zero2) begin
      rd_data2 = '0;
    end else if (hit2) begin
      rd_data2 = wr_data;
    end
  end

  // A same-cycle writeback satisfies the operand through the bypass.
  always_comb begin
    rd_busy1 = pend_q[rd_addr1] && !hit1;
    rd_busy2 = pend_q[rd_addr2] && !hit2;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a decoded single write port, two asynchronous read ports with write-through bypass, and a per-register pending-write scoreboard. It is the register storage of the CPU datapath. Decode and issue use it to read operands, detect in-flight producers, and stall. Writeback uses it to commit results and clear pending state.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register index width; NREGS = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 is hardwired to zero

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe (writeback commit)
- wr_addr  in  ADDR_W  destination register of the write
- wr_data  in  DATA_W  write data
- rd_addr1  in  ADDR_W  read port 1 index
- rd_addr2  in  ADDR_W  read port 2 index
- rd_data1  out  DATA_W  read port 1 data (combinational)
- rd_data2  out  DATA_W  read port 2 data (combinational)
- iss_valid  in  1  an instruction with a destination issues this cycle
- iss_dst  in  ADDR_W  destination register of the issuing instruction
- rd_busy1  out  1  operand on port 1 is not yet available
- rd_busy2  out  1  operand on port 2 is not yet available
- pend_mask  out  NREGS  registered scoreboard, bit i = register i has an outstanding write

## Operation
- Storage: NREGS x DATA_W flops.
- Write decode: one-hot wordline = (wr_en) << wr_addr. Register wr_addr takes wr_data at the clock edge when wr_en=1.
- Zero register (ZERO_REG=1):
  - writes to index 0 are discarded
  - reads of index 0 return 0 and never bypass
  - issues to index 0 never set pend_mask[0]
  - pend_mask[0] is constant 0
- Read, per port n: if wr_en and wr_addr==rd_addrn and the index is not a zero-reg target, rd_datan = wr_data (bypass). Otherwise rd_datan = stored value.
- Scoreboard, next-state per register i:
  - set: iss_valid and iss_dst==i
  - clear: wr_en and wr_addr==i
  - set and clear on the same i in the same cycle: set wins, because the new producer supersedes the old one
  - otherwise the bit holds
- Busy, per port n: rd_busyn = pend_mask[rd_addrn] and not (wr_en and wr_addr==rd_addrn). A same-cycle writeback satisfies the read through the bypass.
- Issue to an already-pending register (WAW) is legal. The bit simply stays set. The block does not count producers; the pipeline keeps at most one in-flight writer per register.
- Reset (rst_n low, asynchronous):
  - all registers = 0
  - pend_mask = 0
  - rd_data and rd_busy then follow the combinational rules above with zeroed state
  - reset asserted mid-operation discards any in-flight write or issue on that edge

## Timing
- Write latency: the value is visible on a read port in the same cycle via bypass, and is architecturally stored from the next edge.
- Read latency: 0 cycles, fully combinational from rd_addr, wr_en, wr_addr and wr_data.
- Scoreboard: iss_valid at edge k makes pend_mask set from after edge k. A write at edge m clears it after edge m, and rd_busy drops combinationally during cycle m itself.
- Both read ports may address the same register or the write target simultaneously. Both ports get identical data and busy.
- No handshake backpressure: wr_en and iss_valid are always accepted.
- Reset deassertion: state holds zero until the first active edge after rst_n rises.

## Test plan
- Reset, then read all indices on both ports -> every rd_data = 0x0000, pend_mask = 0, rd_busy1/2 = 0.
- Write 0xA5A5 to r3 with rd_addr1=3 in the same cycle -> rd_data1 = 0xA5A5 via bypass. Next cycle with wr_en=0 -> rd_data1 = 0xA5A5 from storage. r2 and r4 are unchanged at 0.
- Write 0xFFFF to r0 with ZERO_REG=1, and issue iss_dst=0 -> rd_data of r0 = 0x0000 and pend_mask[0] = 0 on all cycles.
- Scoreboard sequence:
  - issue iss_dst=5, then rd_addr2=5 -> rd_busy2 = 1 and pend_mask = 0x0020
  - writeback r5=0x1234 -> during that cycle rd_busy2 = 0 and rd_data2 = 0x1234; next cycle pend_mask = 0
- Same-cycle issue iss_dst=7 and write r7 (r7 pending) -> after the edge pend_mask[7] = 1 (set wins) and r7 holds the written data.
- Issue r9 and write r9 pending, then pulse rst_n low asynchronously between edges -> pend_mask and all registers read 0 immediately, without waiting for a clk edge.
